pw_mac_scheduler: RTL

Time-multiplexed pointwise (1×1) convolution engine and sequencer for the second convolution layer. It accepts one depthwise output pixel (3 channels) per transaction and steps one signed MAC through every filter/channel pair. It emits one saturated result per filter on a ready/valid stream. Weights and biases are written through a config port while the block is idle, so the layer is not tied to `$readmemh`.

---
 rtl/pw_mac_scheduler_if.sv | 39 +++
 rtl/pw_mac_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pw_mac_scheduler_if.sv
// Config, pixel-in and result-out bundle
// for the pointwise MAC scheduler.
interface pw_mac_scheduler_if #(
  parameter int IN_W   = 14,
  parameter int W_W    = 8,
  parameter int OUT_W  = 16,
  parameter int N_CH   = 3,
  parameter int N_FILT = 9
);
  localparam int AW = $clog2(N_FILT*(N_CH+1));
  localparam int FW = $clog2(N_FILT);

  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  logic [W_W-1:0]         cfg_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_CH*IN_W-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [FW-1:0]          out_filt;
  logic                   out_last;
  logic                   busy;

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_filt, out_last, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_filt, out_last, busy
  );
endinterface

// File: rtl/pw_mac_scheduler.sv
// Time-multiplexed 1x1 conv engine: one signed
// MAC walks every filter/channel pair of a pixel.
module pw_mac_scheduler #(
  parameter int IN_W   = 14,
  parameter int W_W    = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 24,
  parameter int N_CH   = 3,
  parameter int N_FILT = 9
) (
  input logic clk,
  input logic rst,
  pw_mac_scheduler_if.slave bus
);
  localparam int AW    = $clog2(N_FILT*(N_CH+1));
  localparam int FW    = $clog2(N_FILT);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NW    = N_FILT*N_CH;
  localparam int DEPTH = N_FILT*(N_CH+1);
  localparam int PW    = IN_W + W_W;

  localparam logic [AW-1:0] BBASE = AW'(NW);
  localparam logic [AW-1:0] ALIM  = AW'(DEPTH);
  localparam logic [CW-1:0] CLAST = CW'(N_CH-1);
  localparam logic [FW-1:0] FLAST = FW'(N_FILT-1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    EMIT
  } state_e;

  state_e state_q, state_d;

  logic [FW-1:0]           f_q, f_d;
  logic [CW-1:0]           c_q, c_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [IN_W-1:0]  pix_q [N_CH];
  logic signed [IN_W-1:0]  pix_d [N_CH];
  logic signed [W_W-1:0]   cfg_q [DEPTH];
  logic signed [W_W-1:0]   cfg_d [DEPTH];
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic [FW-1:0]           out_filt_q, out_filt_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;

  logic [FW-1:0]           f_nx;
  logic [AW-1:0]           widx;
  logic [AW-1:0]           bidx_nx;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] sum;
  logic                    hi_ovf;
  logic                    lo_ovf;
  logic [OUT_W-1:0]        sat_v;
  logic                    last_c;
  logic                    last_f;
  logic                    cfg_wr;

  // weights live at f*N_CH+c, biases follow them
  always_comb begin
    f_nx    = f_q + 1'b1;
    widx    = AW'(f_q) * AW'(N_CH) + AW'(c_q);
    bidx_nx = BBASE + AW'(f_nx);
    prod    = pix_q[c_q] * cfg_q[widx];
    sum     = acc_q + ACC_W'(prod);
    last_c  = (c_q == CLAST);
    last_f  = (f_q == FLAST);
    cfg_wr  = bus.cfg_we && (state_q == IDLE)
              && (bus.cfg_addr < ALIM);
  end

  // clamp by inspecting the bits above the output sign
  always_comb begin
    hi_ovf = !sum[ACC_W-1]
             && (|sum[ACC_W-2:OUT_W-1]);
    lo_ovf = sum[ACC_W-1]
             && !(&sum[ACC_W-2:OUT_W-1]);
    unique case (1'b1)
      hi_ovf:  sat_v = {1'b0, {(OUT_W-1){1'b1}}};
      lo_ovf:  sat_v = {1'b1, {(OUT_W-1){1'b0}}};
      default: sat_v = sum[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = MAC;
      MAC:  if (last_c) state_d = EMIT;
      EMIT: begin
        if (bus.out_ready)
          state_d = last_f ? IDLE : MAC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_filt  = out_filt_q;
    bus.out_last  = out_last_q;
  end

  always_comb begin
    f_d         = f_q;
    c_d         = c_q;
    acc_d       = acc_q;
    pix_d       = pix_q;
    cfg_d       = cfg_q;
    out_data_d  = out_data_q;
    out_filt_d  = out_filt_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (cfg_wr)
      cfg_d[bus.cfg_addr] = bus.cfg_data;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          for (int c = 0; c < N_CH; c++)
            pix_d[c] = $signed(
              bus.in_data[c*IN_W +: IN_W]);
          f_d   = '0;
          c_d   = '0;
          acc_d = ACC_W'(cfg_q[BBASE]);
        end
      end
      MAC: begin
        acc_d = sum;
        if (last_c) begin
          out_data_d  = sat_v;
          out_filt_d  = f_q;
          out_last_d  = last_f;
          out_valid_d = 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (!last_f) begin
            f_d   = f_nx;
            c_d   = '0;
            acc_d = ACC_W'(cfg_q[bidx_nx]);
          end else begin
            out_last_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q         <= '0;
      c_q         <= '0;
      acc_q       <= '0;
      pix_q       <= '{default: '0};
      cfg_q       <= '{default: '0};
      out_data_q  <= '0;
      out_filt_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      f_q         <= f_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      pix_q       <= pix_d;
      cfg_q       <= cfg_d;
      out_data_q  <= out_data_d;
      out_filt_q  <= out_filt_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
